// File: rtl/dbu_pkg.sv
// Shared definitions for the debug unit: FSM encoding and view-select codes.
package dbu_pkg;

  localparam logic [1:0] HALT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;

  typedef enum logic [1:0] {
    StHalt = HALT,
    StRun  = RUN,
    StStep = STEP
  } dbu_state_e;

  // sel value that routes the register/memory word to the display
  localparam logic [2:0] SEL_RF_MEM = 3'd0;
  // sel value that shows the CPU cycle counter (when that feature is built)
  localparam logic [2:0] SEL_CYC    = 3'd7;

endpackage

// File: rtl/debug_unit_if.sv
// Debug-port bundle between board I/O / CPU (master) and the debug unit (slave).
interface debug_unit_if;

  logic        succ;
  logic        step;
  logic        inc;
  logic        dec;
  logic [2:0]  sel;
  logic [1:0]  sub;
  logic [31:0] status;
  logic [15:0] control_sign;
  logic [31:0] m_data;
  logic [31:0] r_data;
  logic        cpu_en;
  logic [2:0]  sel0;
  logic [1:0]  sel1;
  logic [31:0] m_rf_addr;
  logic [31:0] disp_data;
  logic [15:0] disp_ctrl;

  modport master (
    output succ, step, inc, dec, sel, sub, status, control_sign, m_data, r_data,
    input  cpu_en, sel0, sel1, m_rf_addr, disp_data, disp_ctrl
  );

  modport slave (
    input  succ, step, inc, dec, sel, sub, status, control_sign, m_data, r_data,
    output cpu_en, sel0, sel1, m_rf_addr, disp_data, disp_ctrl
  );

endinterface

// File: rtl/debug_unit_btn_edge.sv
// Button conditioner: 2-FF synchroniser followed by a rising-edge detector.
// The pulse is one clock wide and appears two edges after the press is sampled.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronise the button and remember its previous synchronised value
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/debug_unit.sv
// Host-side driver for the CPU debug port: run/step clock enable, inspect-address
// walker and registered display words.
// Optional feature: define DBU_CYCLE_CNT_EN to add a CPU cycle counter shown on sel==7.
module debug_unit
  import dbu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned ADDR_STEP = 4
) (
  input logic         clk,
  input logic         rst,
  debug_unit_if.slave dbg
);

  logic              succ_s1_q, succ_s_q;
  logic              step_p, inc_p, dec_p;
  dbu_state_e        state_q;
  logic              cpu_en_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       stat_word;
  logic [31:0]       disp_data_q;
  logic [15:0]       disp_ctrl_q;

  btn_edge u_step (.clk(clk), .rst(rst), .btn_i(dbg.step), .pulse_o(step_p));
  btn_edge u_inc  (.clk(clk), .rst(rst), .btn_i(dbg.inc),  .pulse_o(inc_p));
  btn_edge u_dec  (.clk(clk), .rst(rst), .btn_i(dbg.dec),  .pulse_o(dec_p));

  // succ is a level switch: synchronise only, no edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      succ_s1_q <= 1'b0;
      succ_s_q  <= 1'b0;
    end else begin
      succ_s1_q <= dbg.succ;
      succ_s_q  <= succ_s1_q;
    end
  end

  // Run/step FSM; cpu_en is registered together with the state it decodes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StHalt;
      cpu_en_q <= 1'b0;
    end else begin
      case (state_q)
        StHalt: begin
          if (succ_s_q) begin
            state_q  <= StRun;
            cpu_en_q <= 1'b1;
          end else if (step_p) begin
            state_q  <= StStep;
            cpu_en_q <= 1'b1;
          end else begin
            cpu_en_q <= 1'b0;
          end
        end
        StRun: begin
          if (!succ_s_q) begin
            state_q  <= StHalt;
            cpu_en_q <= 1'b0;
          end else begin
            cpu_en_q <= 1'b1;
          end
        end
        // Single step lasts exactly one cycle; step presses here are dropped
        StStep: begin
          state_q  <= StHalt;
          cpu_en_q <= 1'b0;
        end
        default: begin
          state_q  <= StHalt;
          cpu_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Inspect address: simultaneous inc and dec cancel; wraps modulo 2^ADDR_W
  always_comb begin
    addr_d = addr_q;
    if (inc_p && !dec_p) begin
      addr_d = addr_q + ADDR_W'(ADDR_STEP);
    end else if (dec_p && !inc_p) begin
      addr_d = addr_q - ADDR_W'(ADDR_STEP);
    end
  end

  // Address register, independent of the FSM state
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

`ifdef DBU_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  // Count CPU-enabled cycles; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (cpu_en_q) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign stat_word = (dbg.sel == SEL_CYC) ? cyc_q : dbg.status;
`else
  assign stat_word = dbg.status;
`endif

  // Display registers refresh every cycle from the currently selected source
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_data_q <= '0;
      disp_ctrl_q <= '0;
    end else begin
      disp_data_q <= (dbg.sel == SEL_RF_MEM) ? (dbg.sub[0] ? dbg.m_data : dbg.r_data)
                                             : stat_word;
      disp_ctrl_q <= dbg.control_sign;
    end
  end

  assign dbg.cpu_en    = cpu_en_q;
  assign dbg.sel0      = dbg.sel;
  assign dbg.sel1      = dbg.sub;
  assign dbg.m_rf_addr = 32'(addr_q);
  assign dbg.disp_data = disp_data_q;
  assign dbg.disp_ctrl = disp_ctrl_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit. Inputs change on the falling edge, outputs are
// compared on the falling edge against a cycle-level reference model.
module tb_debug_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_unit_if dbg_if ();

  debug_unit #(.ADDR_W(10), .ADDR_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model. A button/switch value sampled at edge e influences the
  // machine at edge e+2; a step/inc/dec press is a 0->1 change in those samples.
  logic [2:0]  h_step, h_inc, h_dec, h_succ;  // [0] = previous edge's sample
  int          m_mode;                        // 0 halted, 1 running, 2 stepping
  bit          m_en;
  int unsigned m_addr;
  logic [31:0] m_disp;
  logic [15:0] m_ctrl;
  logic [31:0] m_cyc;

  always @(posedge clk) begin
    bit step_p, inc_p, dec_p, succ_s;
    if (!rst) begin
      h_step = '0; h_inc = '0; h_dec = '0; h_succ = '0;
      m_mode = 0; m_en = 0; m_addr = 0; m_disp = '0; m_ctrl = '0; m_cyc = '0;
    end else begin
      step_p = h_step[1] & ~h_step[2];
      inc_p  = h_inc[1] & ~h_inc[2];
      dec_p  = h_dec[1] & ~h_dec[2];
      succ_s = h_succ[1];
      m_disp = dbg_if.status;
`ifdef DBU_CYCLE_CNT_EN
      if (dbg_if.sel == 3'd7) m_disp = m_cyc;
`endif
      if (dbg_if.sel == 3'd0) m_disp = dbg_if.sub[0] ? dbg_if.m_data : dbg_if.r_data;
      m_ctrl = dbg_if.control_sign;
      if (m_en) m_cyc = m_cyc + 32'd1;
      if (m_mode == 2) m_mode = 0;
      else if (m_mode == 1) begin
        if (!succ_s) m_mode = 0;
      end else if (succ_s) m_mode = 1;
      else if (step_p) m_mode = 2;
      m_en = (m_mode != 0);
      if (inc_p && !dec_p) m_addr = (m_addr + 4) % 1024;
      if (dec_p && !inc_p) m_addr = (m_addr + 1024 - 4) % 1024;
      h_step = {h_step[1:0], dbg_if.step};
      h_inc  = {h_inc[1:0], dbg_if.inc};
      h_dec  = {h_dec[1:0], dbg_if.dec};
      h_succ = {h_succ[1:0], dbg_if.succ};
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Hold the chosen button(s) for two cycles, then release and let it settle
  task automatic press(input bit i, input bit d, input bit s);
    dbg_if.inc = i; dbg_if.dec = d; dbg_if.step = s;
    repeat (2) @(negedge clk);
    dbg_if.inc = 1'b0; dbg_if.dec = 1'b0; dbg_if.step = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    dbg_if.status = 32'hA5A5_0F0F;
    dbg_if.control_sign = 16'hBEEF;
    dbg_if.r_data = 32'h1111_2222;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_if.cpu_en !== 1'b0) begin
      errors++; $display("FAIL reset_cpu_en: got %b want 0", dbg_if.cpu_en);
    end
    checks++;
    if (dbg_if.m_rf_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", dbg_if.m_rf_addr);
    end
    checks++;
    if (dbg_if.disp_data !== 32'd0) begin
      errors++; $display("FAIL reset_disp_data: got %h want 0", dbg_if.disp_data);
    end
    checks++;
    if (dbg_if.disp_ctrl !== 16'd0) begin
      errors++; $display("FAIL reset_disp_ctrl: got %h want 0", dbg_if.disp_ctrl);
    end
    rst = 1'b1;
  endtask

  task automatic test_step();
    int ones = 0;
    int first = -1;
    dbg_if.succ = 1'b0;
    dbg_if.step = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 5) dbg_if.step = 1'b0;
      checks++;
      if (dbg_if.cpu_en !== m_en) begin
        errors++; $display("FAIL step_cpu_en cycle %0d: got %b want %b", i, dbg_if.cpu_en, m_en);
      end
      if (dbg_if.cpu_en === 1'b1) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (ones != 1 || first != 3) begin
      errors++; $display("FAIL step_shape: got %0d cycles from %0d want 1 from 3", ones, first);
    end
  endtask

  task automatic test_addr();
    do_reset();
    repeat (3) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (dbg_if.m_rf_addr !== 32'd8 || dbg_if.m_rf_addr !== 32'(m_addr)) begin
      errors++; $display("FAIL addr_inc_dec: got %h want 8", dbg_if.m_rf_addr);
    end
    do_reset();
    repeat (3) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (dbg_if.m_rf_addr !== 32'h3F4 || dbg_if.m_rf_addr !== 32'(m_addr)) begin
      errors++; $display("FAIL addr_wrap: got %h want 3f4", dbg_if.m_rf_addr);
    end
    press(1'b1, 1'b1, 1'b0);
    checks++;
    if (dbg_if.m_rf_addr !== 32'h3F4) begin
      errors++; $display("FAIL addr_inc_and_dec: got %h want 3f4", dbg_if.m_rf_addr);
    end
  endtask

  task automatic test_run();
    int ones = 0;
    int first = -1;
    do_reset();
    dbg_if.succ = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 20) dbg_if.succ = 1'b0;
      if (i == 8) dbg_if.step = 1'b1;
      if (i == 10) dbg_if.step = 1'b0;
      checks++;
      if (dbg_if.cpu_en !== m_en) begin
        errors++; $display("FAIL run_cpu_en cycle %0d: got %b want %b", i, dbg_if.cpu_en, m_en);
      end
      if (dbg_if.cpu_en === 1'b1) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (ones != 20 || first != 3) begin
      errors++; $display("FAIL run_shape: got %0d cycles from %0d want 20 from 3", ones, first);
    end
  endtask

  task automatic test_disp();
    dbg_if.sel = 3'd0; dbg_if.sub = 2'b01; dbg_if.m_data = 32'hDEAD_BEEF;
    dbg_if.control_sign = 16'h1357;
    @(negedge clk);
    checks++;
    if (dbg_if.disp_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL disp_mem: got %h want deadbeef", dbg_if.disp_data);
    end
    checks++;
    if (dbg_if.disp_ctrl !== 16'h1357) begin
      errors++; $display("FAIL disp_ctrl: got %h want 1357", dbg_if.disp_ctrl);
    end
    dbg_if.sub = 2'b10; dbg_if.r_data = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (dbg_if.disp_data !== 32'h0000_1234) begin
      errors++; $display("FAIL disp_reg: got %h want 00001234", dbg_if.disp_data);
    end
    checks++;
    if (dbg_if.sel1 !== 2'b10) begin
      errors++; $display("FAIL sel1_fwd: got %b want 10", dbg_if.sel1);
    end
    dbg_if.sel = 3'd3; dbg_if.status = 32'h0000_0055;
    #1;
    checks++;
    if (dbg_if.sel0 !== 3'd3) begin
      errors++; $display("FAIL sel0_fwd: got %0d want 3", dbg_if.sel0);
    end
    @(negedge clk);
    checks++;
    if (dbg_if.disp_data !== 32'h0000_0055) begin
      errors++; $display("FAIL disp_status: got %h want 00000055", dbg_if.disp_data);
    end
  endtask

  task automatic test_cycle_cnt();
    logic [31:0] want;
    do_reset();
    dbg_if.sel = 3'd3; dbg_if.status = 32'hCAFE_0001;
    repeat (3) press(1'b0, 1'b0, 1'b1);
    dbg_if.succ = 1'b1;
    repeat (10) @(negedge clk);
    dbg_if.succ = 1'b0;
    repeat (6) @(negedge clk);
    dbg_if.sel = 3'd7;
    @(negedge clk);
`ifdef DBU_CYCLE_CNT_EN
    want = 32'd13;
`else
    want = 32'hCAFE_0001;
`endif
    checks++;
    if (dbg_if.disp_data !== want || dbg_if.disp_data !== m_disp) begin
      errors++; $display("FAIL cyc_count: got %h want %h", dbg_if.disp_data, want);
    end
    dbg_if.succ = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_if.cpu_en !== 1'b0) begin
      errors++; $display("FAIL cyc_reset_en: got %b want 0", dbg_if.cpu_en);
    end
    dbg_if.succ = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
`ifdef DBU_CYCLE_CNT_EN
    want = 32'd0;
`else
    want = 32'hCAFE_0001;
`endif
    checks++;
    if (dbg_if.disp_data !== want) begin
      errors++; $display("FAIL cyc_reset_val: got %h want %h", dbg_if.disp_data, want);
    end
    checks++;
    if (dbg_if.cpu_en !== 1'b0) begin
      errors++; $display("FAIL cyc_no_partial: got %b want 0", dbg_if.cpu_en);
    end
  endtask

  task automatic test_random();
    logic [2:0] s;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_if.cpu_en !== m_en || dbg_if.m_rf_addr !== 32'(m_addr)
          || dbg_if.disp_data !== m_disp || dbg_if.disp_ctrl !== m_ctrl) begin
        errors++;
        $display("FAIL rand cycle %0d: got en=%b a=%h d=%h c=%h want en=%b a=%h d=%h c=%h", i,
                 dbg_if.cpu_en, dbg_if.m_rf_addr, dbg_if.disp_data, dbg_if.disp_ctrl,
                 m_en, 32'(m_addr), m_disp, m_ctrl);
      end
      if ($urandom_range(3) == 0) dbg_if.step = ~dbg_if.step;
      if ($urandom_range(3) == 0) dbg_if.inc = ~dbg_if.inc;
      if ($urandom_range(3) == 0) dbg_if.dec = ~dbg_if.dec;
      if ($urandom_range(15) == 0) dbg_if.succ = ~dbg_if.succ;
      s = 3'($urandom_range(7));
      if ($urandom_range(1) == 0) s = ($urandom_range(1) == 0) ? 3'd0 : 3'd7;
      dbg_if.sel = s;
      dbg_if.sub = 2'($urandom_range(3));
      dbg_if.status = $urandom;
      dbg_if.m_data = $urandom;
      dbg_if.r_data = $urandom;
      dbg_if.control_sign = 16'($urandom);
      rst = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
    end
    rst = 1'b1;
  endtask

  initial begin
    dbg_if.succ = 1'b0; dbg_if.step = 1'b0; dbg_if.inc = 1'b0; dbg_if.dec = 1'b0;
    dbg_if.sel = 3'd0; dbg_if.sub = 2'd0; dbg_if.status = '0; dbg_if.control_sign = '0;
    dbg_if.m_data = '0; dbg_if.r_data = '0;
    test_reset();
    test_step();
    test_addr();
    test_run();
    test_disp();
    test_cycle_cnt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
